nibble_exec: RTL
================

Name: nibble_exec

Overview:
Decode/execute stage that sits directly downstream of the PC + program ROM + fetch register path. It consumes the fetched opcode/operand nibbles and the raw ROM byte. It sequences that path with a phase FSM: it drives the PC increment/load and fetch-enable controls and owns the 4-bit accumulator, the flags and an output port with a valid/ready handshake.

Parameters:
ADDR_W, 12, PC/jump address width; the jump address is {operando, program_byte}, so ADDR_W = 4 + 8 is required.
NOP_HALT, 0, when 1, opcode 0xF halts the core; when 0, 0xF is a NOP.

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
instruccion  in  4  opcode from the fetch register
operando  in  4  operand nibble from the fetch register
program_byte  in  8  ROM output at the current PC (low byte of the jump target)
data_in  in  4  input port sampled by IN
out_ready  in  1  downstream accepts data_out
enablePC  out  1  PC increments this cycle
enableFetch  out  1  fetch register captures this cycle
load  out  1  PC loads valor_load this cycle (active-high, has priority over enablePC)
valor_load  out  12  jump target {operando, program_byte}
acc  out  4  accumulator
flag_c  out  1  carry flag
flag_z  out  1  zero flag
data_out  out  4  output port register
out_valid  out  1  data_out valid
halted  out  1  core is in HALT

Behaviour:
- Reset, while rst is low: state = FETCH; acc, flag_c, flag_z, data_out = 0; out_valid = 0; halted = 0. enablePC, enableFetch and load are forced to 0.
- Reset asserted mid-operation aborts at once: a pending out_valid drops and no partial update survives.
- State FETCH: enableFetch = 1, enablePC = 1. Next state is EXEC.
- State EXEC:
  - instruccion/operando now hold the fetched byte, and program_byte reflects ROM[PC+1].
  - Each instruction executes in this one cycle, then the FSM returns to FETCH unless stated otherwise.
- Opcodes (v = operando, A = acc):
  - 0x0 NOP.
  - 0x1 LIT: A = v; flags unchanged.
  - 0x2 ADDI: {C, A} = A + v (5-bit sum); Z = (A_new == 0).
  - 0x3 CMPI: A unchanged; C = (A >= v); Z = (A == v).
  - 0x4 NANDI: A = ~(A & v); Z updated; C unchanged.
  - 0x5 JC, 0x6 JNC, 0x7 JZ, 0x8 JNZ, 0x9 JMP: two-byte instructions.
    - Taken: load = 1 and valor_load = {v, program_byte}.
    - Not taken: enablePC = 1 to skip the address byte.
    - The condition is evaluated on the flags as registered at EXEC.
  - 0xA IN: A = data_in; flags unchanged.
  - 0xB OUT: data_out = A; out_valid = 1; next state WAIT_OUT.
  - 0xC: reserved (see Optional Feature).
  - 0xD, 0xE: NOP.
  - 0xF: HALT if NOP_HALT = 1, otherwise NOP.
- State WAIT_OUT:
  - All PC/fetch enables are 0 and out_valid is held.
  - When out_valid && out_ready is sampled at a rising edge, out_valid clears and the next state is FETCH.
  - If out_ready is already high in the first WAIT_OUT cycle, the state lasts exactly one cycle.
- State HALT: halted = 1 and all enables are 0; the core stays here until reset.
- Arithmetic is modulo 16, and the address wraps at 0xFFF as handled by the PC.
- Throughput: 2 cycles per instruction, plus one cycle per OUT handshake wait.

Optional Feature:
Macro: NIBBLE_SUBI_EN.
- Defined: opcode 0xC = SUBI: A = A - v mod 16; C = (A_old >= v), meaning no borrow; Z = (A_new == 0).
- Undefined: opcode 0xC is a NOP; acc and flags are unchanged.

Test Plan:
- Reset then release with ROM 0x15, 0x2C: after 4 cycles acc = 0x1, flag_c = 1, flag_z = 0; enablePC/enableFetch = 1 only in FETCH cycles.
- Program 0x13, 0x33, 0x7A, 0x40:
  - JZ is taken: load = 1 for exactly one EXEC cycle with valor_load = 0xA40.
  - Repeat with CMPI 0x4: JZ is not taken, enablePC = 1 in EXEC and load = 0.
- 0x19 then OUT 0xB0 with out_ready = 0 for 5 cycles: data_out = 0x9, out_valid = 1, PC enables stay 0; out_ready = 1 -> out_valid drops next edge and FETCH resumes.
- rst pulsed low during WAIT_OUT -> out_valid, acc, data_out = 0 immediately (asynchronously); restart in FETCH.
- NOP_HALT = 1 with opcode 0xF0 -> halted = 1 and all enables stay 0 for 20 cycles.
- With NIBBLE_SUBI_EN defined, LIT 2 then 0xC3 -> acc = 0xF, flag_c = 0, flag_z = 0. Undefined -> acc stays 0x2.

Source files
------------

// File: rtl/nibble_exec.sv
// nibble_exec: 4-bit decode/execute stage driving PC/fetch; 2 cycles per instruction (FETCH, EXEC).
// OUT parks in WAIT_OUT holding out_valid until out_ready; opcode 0xC is SUBI when NIBBLE_SUBI_EN is defined.
module nibble_exec #(
  parameter int ADDR_W   = 12,
  parameter bit NOP_HALT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        instruccion,
  input  logic [3:0]        operando,
  input  logic [7:0]        program_byte,
  input  logic [3:0]        data_in,
  input  logic              out_ready,
  output logic              enablePC,
  output logic              enableFetch,
  output logic              load,
  output logic [ADDR_W-1:0] valor_load,
  output logic [3:0]        acc,
  output logic              flag_c,
  output logic              flag_z,
  output logic [3:0]        data_out,
  output logic              out_valid,
  output logic              halted
);

  localparam logic [1:0] FETCH    = 2'd0;
  localparam logic [1:0] EXEC     = 2'd1;
  localparam logic [1:0] WAIT_OUT = 2'd2;
  localparam logic [1:0] HALT     = 2'd3;

  logic [1:0] state, state_n;
  logic [3:0] acc_n, data_out_n;
  logic       flag_c_n, flag_z_n, out_valid_n;
  logic       en_pc, en_fetch, do_load;
  logic [4:0] sum;
  logic [3:0] nand_v;
  logic       take;

  assign sum        = {1'b0, acc} + {1'b0, operando};
  assign nand_v     = ~(acc & operando);
  assign valor_load = {operando, program_byte};

`ifdef NIBBLE_SUBI_EN
  logic [3:0] diff;
  assign diff = acc - operando;
`endif

  always_comb begin
    unique case (instruccion)
      4'h5:    take = flag_c;
      4'h6:    take = ~flag_c;
      4'h7:    take = flag_z;
      4'h8:    take = ~flag_z;
      4'h9:    take = 1'b1;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    flag_c_n    = flag_c;
    flag_z_n    = flag_z;
    data_out_n  = data_out;
    out_valid_n = out_valid;
    en_pc       = 1'b0;
    en_fetch    = 1'b0;
    do_load     = 1'b0;
    case (state)
      FETCH: begin
        en_fetch = 1'b1;
        en_pc    = 1'b1;
        state_n  = EXEC;
      end
      EXEC: begin
        state_n = FETCH;
        case (instruccion)
          4'h1: acc_n = operando;
          4'h2: begin
            {flag_c_n, acc_n} = sum;
            flag_z_n          = (sum[3:0] == 4'h0);
          end
          4'h3: begin
            flag_c_n = (acc >= operando);
            flag_z_n = (acc == operando);
          end
          4'h4: begin
            acc_n    = nand_v;
            flag_z_n = (nand_v == 4'h0);
          end
          // Jumps: a taken branch loads the PC, otherwise step over the address byte.
          4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
            do_load = take;
            en_pc   = ~take;
          end
          4'hA: acc_n = data_in;
          4'hB: begin
            data_out_n  = acc;
            out_valid_n = 1'b1;
            state_n     = WAIT_OUT;
          end
`ifdef NIBBLE_SUBI_EN
          4'hC: begin
            acc_n    = diff;
            flag_c_n = (acc >= operando);
            flag_z_n = (diff == 4'h0);
          end
`endif
          4'hF: if (NOP_HALT) state_n = HALT;
          default: ;
        endcase
      end
      WAIT_OUT: begin
        if (out_valid && out_ready) begin
          out_valid_n = 1'b0;
          state_n     = FETCH;
        end
      end
      default: state_n = HALT;
    endcase
  end

  // Controls are gated by reset so the PC/fetch path stays frozen while rst is low.
  assign enablePC    = en_pc & rst;
  assign enableFetch = en_fetch & rst;
  assign load        = do_load & rst;
  assign halted      = (state == HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH;
      acc       <= 4'h0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      data_out  <= 4'h0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      flag_c    <= flag_c_n;
      flag_z    <= flag_z_n;
      data_out  <= data_out_n;
      out_valid <= out_valid_n;
    end
  end

endmodule
